// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall handling and the
// IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = 32'h00000000,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              PCSrcE,
    input  logic [DATA_W-1:0] PCTargetE,
    input  logic [DATA_W-1:0] InstrF,
    output logic [DATA_W-1:0] PCF,
    output logic [DATA_W-1:0] InstrD,
    output logic [DATA_W-1:0] PCD,
    output logic [DATA_W-1:0] PCPlus4D,
    output logic              ValidD
);

    logic [DATA_W-1:0] pc_p0;
    logic [DATA_W-1:0] pcplus4_p0;
    logic [DATA_W-1:0] pcnext_p0;

    logic [DATA_W-1:0] instr_p1;
    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] pcplus4_p1;
    logic              vld_p1;

    // Low two bits of a redirect target are dropped so PCF stays word-aligned.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

    // Wraps naturally at the top of the address space.
    function automatic logic [DATA_W-1:0] pc_inc4(input logic [DATA_W-1:0] a);
        return a + DATA_W'(4);
    endfunction

    // ---- stage p0: fetch address selection ----
    always_comb begin
        pcplus4_p0 = pc_inc4(pc_p0);
        pcnext_p0  = PCSrcE ? word_align(PCTargetE) : pcplus4_p0;
    end

    // A redirect is never lost to a stall: PCSrcE forces the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else if (PCSrcE || !StallF) begin
            pc_p0 <= pcnext_p0;
        end
    end

    // ---- stage p1: IF/ID register ----
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            instr_p1   <= NOP_INSTR;
            pc_p1      <= '0;
            pcplus4_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (!StallD) begin
            instr_p1   <= InstrF;
            pc_p1      <= pc_p0;
            pcplus4_p1 <= pcplus4_p0;
            vld_p1     <= 1'b1;
        end
    end

    assign PCF      = pc_p0;
    assign InstrD   = instr_p1;
    assign PCD      = pc_p1;
    assign PCPlus4D = pcplus4_p1;
    assign ValidD   = vld_p1;

endmodule
